// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider op/state encodings, the decoder control word
// and small two's-complement helpers used by the serial divider.
package alu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } divop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  typedef struct packed {
    logic   div_en;
    divop_t divop;
  } ctrl_t;

  // RV32M funct3 100..111 lines up with the divop_t encoding in its low bits.
  function automatic divop_t funct3_to_divop(input logic [2:0] funct3);
    return divop_t'(funct3[1:0]);
  endfunction

  function automatic logic op_is_signed(input divop_t op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] x);
    return (~x) + ONE;
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? twos_neg(x) : x;
  endfunction

endpackage

// File: rtl/serial_divider_if.sv
// Request/response handshake between the execute stage (master) and the divider (slave).
interface serial_divider_if;
  import alu_pkg::*;

  logic            valid_i;
  logic            ready_o;
  divop_t          op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic            busy_o;

  modport master (
    output valid_i, op_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, result_o, busy_o
  );

  modport slave (
    input  valid_i, op_i, a_i, b_i, ready_i,
    output ready_o, valid_o, result_o, busy_o
  );
endinterface

// File: rtl/serial_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract,
// and shift the resulting quotient bit into the dividend register's LSB.
module div_step
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] dvd_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] dvd_o
);

  logic [XLEN:0] rem_sh_s;
  logic [XLEN:0] diff_s;
  logic          q_bit_s;

  // The partial remainder can reach 2*dvs-1, so the trial subtract needs XLEN+1 bits.
  always_comb begin
    rem_sh_s = {rem_i, dvd_i[XLEN-1]};
    diff_s   = rem_sh_s - {1'b0, dvs_i};
    q_bit_s  = ~diff_s[XLEN];
    rem_o    = q_bit_s ? diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
    dvd_o    = {dvd_i[XLEN-2:0], q_bit_s};
  end

endmodule

// File: rtl/serial_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU; one result per
// request over valid/ready, XLEN iterations plus a sign-fix cycle.
module serial_divider
  import alu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  serial_divider_if.slave  div_if
);

  div_state_t      state_q, state_d;
  divop_t          op_q, op_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            sgn_s;
  logic [XLEN-1:0] step_rem_s;
  logic [XLEN-1:0] step_dvd_s;

  div_step u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem_s),
    .dvd_o (step_dvd_s)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    valid_d   = valid_q;
    sgn_s     = op_is_signed(div_if.op_i);

    case (state_q)
      IDLE: begin
        if (div_if.valid_i) begin
          op_d = div_if.op_i;
          if (div_if.b_i == {XLEN{1'b0}}) begin
            result_d = ((div_if.op_i == DIV) || (div_if.op_i == DIVU)) ? ALL_ONE : div_if.a_i;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else if (sgn_s && (div_if.a_i == INT_MIN) && (div_if.b_i == ALL_ONE)) begin
            result_d = (div_if.op_i == DIV) ? INT_MIN : {XLEN{1'b0}};
            valid_d  = 1'b1;
            state_d  = DONE;
          end else begin
            dvd_d     = magnitude(div_if.a_i, sgn_s);
            dvs_d     = magnitude(div_if.b_i, sgn_s);
            rem_d     = {XLEN{1'b0}};
            cnt_d     = CNT_W'(XLEN - 1);
            neg_quo_d = sgn_s & (div_if.a_i[XLEN-1] ^ div_if.b_i[XLEN-1]);
            neg_rem_d = sgn_s & div_if.a_i[XLEN-1];
            state_d   = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = step_rem_s;
        dvd_d = step_dvd_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX: begin
        // After the last iteration dvd_q holds the quotient magnitude.
        case (op_q)
          DIV:     result_d = neg_quo_q ? twos_neg(dvd_q) : dvd_q;
          DIVU:    result_d = dvd_q;
          REM:     result_d = neg_rem_q ? twos_neg(rem_q) : rem_q;
          REMU:    result_d = rem_q;
          default: result_d = dvd_q;
        endcase
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (div_if.ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= DIV;
      dvd_q     <= {XLEN{1'b0}};
      dvs_q     <= {XLEN{1'b0}};
      rem_q     <= {XLEN{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= {XLEN{1'b0}};
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign div_if.ready_o  = ready_q;
  assign div_if.valid_o  = valid_q;
  assign div_if.result_o = result_q;
  assign div_if.busy_o   = busy_q;

endmodule

// File: tb/tb_serial_divider.sv
// Randomized scoreboard bench for serial_divider: directed corner cases, backpressure,
// mid-operation reset, then random ops against an arithmetic reference model.
module tb_serial_divider;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  logic clk;
  logic rst_ni;
  serial_divider_if dif ();

  serial_divider dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .div_if (dif)
  );

  int   checks;
  int   errors;
  int   cyc;
  exp_t exp_q[$];
  bit   in_rsp;
  bit   hs_pending;
  logic [31:0] held;
  bit   hold_ready;
  bit   stall_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: RV32M semantics expressed with plain integer arithmetic.
  function automatic void ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
    int sa, sb;
    sa  = a;
    sb  = b;
    lat = 34;
    if (b == 32'd0) begin
      r   = (op == 2'd0 || op == 2'd1) ? 32'hFFFF_FFFF : a;
      lat = 1;
    end else if ((op == 2'd0 || op == 2'd2) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r   = (op == 2'd0) ? 32'h8000_0000 : 32'd0;
      lat = 1;
    end else begin
      case (op)
        2'd0:    r = sa / sb;
        2'd1:    r = a / b;
        2'd2:    r = sa % sb;
        default: r = a % b;
      endcase
    end
  endfunction

  // Monitor: pops the expectation when a result first appears and checks it stays put.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (hs_pending) begin
        in_rsp     = 1'b0;
        hs_pending = 1'b0;
      end
      if (dif.valid_o) begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          held   = dif.result_o;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %h expected no response", dif.result_o);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result", dif.result_o, e.res);
            check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          end
        end else begin
          check("result_stable", dif.result_o, held);
        end
        if (dif.ready_i) hs_pending = 1'b1;
      end else if (in_rsp) begin
        check("valid_held", {31'd0, dif.valid_o}, 32'd1);
        in_rsp = 1'b0;
      end
    end
  end

  // Consumer-side ready driver.
  initial begin
    dif.ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dif.ready_i = hold_ready ? 1'b0 : (stall_en ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, output int acc);
    int   n;
    exp_t e;
    n = 0;
    while (!dif.ready_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!dif.ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready_o=0 expected 1 within 200 cycles");
    end
    dif.valid_i = 1'b1;
    dif.op_i    = divop_t'(op);
    dif.a_i     = a;
    dif.b_i     = b;
    acc         = cyc + 1;
    if (push) begin
      ref_div(op, a, b, e.res, e.lat);
      e.acc = acc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    dif.valid_i = 1'b0;
    dif.op_i    = divop_t'($urandom_range(0, 3));
    dif.a_i     = $urandom;
    dif.b_i     = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_rsp || dif.busy_o) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0 || in_rsp) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    int acc;
    logic [31:0] cap;
    logic [31:0] a, b;
    logic [1:0]  op;
    int sel;

    checks = 0; errors = 0; cyc = 0;
    in_rsp = 1'b0; hs_pending = 1'b0; held = 32'd0;
    hold_ready = 1'b0; stall_en = 1'b0;
    rst_ni = 1'b0;
    dif.valid_i = 1'b0; dif.op_i = DIV; dif.a_i = 32'd0; dif.b_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, dif.ready_o}, 32'd1);
    check("reset_valid", {31'd0, dif.valid_o}, 32'd0);
    check("reset_busy", {31'd0, dif.busy_o}, 32'd0);
    check("reset_result", dif.result_o, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Directed operations.
    issue(2'd1, 32'd100, 32'd7, 1'b1, acc);
    issue(2'd3, 32'd100, 32'd7, 1'b1, acc);
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, 1'b1, acc);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, acc);
    issue(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b1, acc);
    for (int i = 0; i < 4; i++) issue(i[1:0], 32'd5, 32'd0, 1'b1, acc);
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, acc);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, acc);
    issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, acc);
    drain();

    // Backpressure: hold the result, poke a request that must be ignored.
    hold_ready = 1'b1;
    issue(2'd1, 32'd1000, 32'd3, 1'b1, acc);
    for (int n = 0; n < 60 && !dif.valid_o; n++) begin
      @(posedge clk);
      #1;
    end
    cap = dif.result_o;
    check("bp_result_value", cap, 32'd333);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, dif.valid_o}, 32'd1);
      check("bp_result", dif.result_o, cap);
      check("bp_ready", {31'd0, dif.ready_o}, 32'd0);
      check("bp_busy", {31'd0, dif.busy_o}, 32'd1);
      @(posedge clk);
      #1;
      if (i == 3) begin
        dif.valid_i = 1'b1; dif.op_i = DIVU; dif.a_i = 32'd5; dif.b_i = 32'd0;
      end
      if (i == 6) dif.valid_i = 1'b0;
    end
    hold_ready = 1'b0;
    drain();

    // Reset during CALC discards the in-flight operation.
    issue(2'd1, 32'd12345, 32'd67, 1'b0, acc);
    while (cyc < acc + 10) begin
      @(posedge clk);
      #1;
    end
    check("calc_busy", {31'd0, dif.busy_o}, 32'd1);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    check("rst_mid_ready", {31'd0, dif.ready_o}, 32'd1);
    check("rst_mid_valid", {31'd0, dif.valid_o}, 32'd0);
    check("rst_mid_result", dif.result_o, 32'd0);
    check("rst_mid_busy", {31'd0, dif.busy_o}, 32'd0);
    issue(2'd0, 32'hFFFF_FC18, 32'd7, 1'b1, acc);
    drain();

    // Random operations with consumer stalls.
    stall_en = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
        3:       b = {{28{b[31]}}, b[3:0]};
        default: ;
      endcase
      issue(op, a, b, 1'b1, acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
